traffic_light_ctrl: RTL and testbench
=====================================

// Module: traffic_light_ctrl
// PURPOSE
//  Traffic-signal sequencer that drives tr_light / tr_light_tick into Decision_CrossWalk.
//  Starts on the first fix_coord_valid pulse, then cycles car-green -> yellow -> all-red
//  -> pedestrian walk -> flash -> all-red. Supports pedestrian-request green truncation
//  and walk extension while a pedestrian remains in the crosswalk. Drives lamps and a
//  seconds countdown for the VGA overlay.
// PARAMETERS
//  TICK_DIV     100_000_000  clk cycles per 1 s tick (>=2)
//  GREEN_S      20           car green duration, s (1..127, applies to all *_S)
//  YELLOW_S     3            car yellow duration, s
//  ALLRED_S     1            all-red clearance, s (used by both ALL_RED1 and ALL_RED2)
//  WALK_S       10           pedestrian steady-walk duration, s
//  FLASH_S      5            pedestrian flashing-walk duration, s
//  MIN_GREEN_S  5            minimum green before a ped request may end it (<=GREEN_S)
//  EXT_S        5            max 1 s extensions of PED_FLASH
// PORTS
//  clk              in   1  system clock
//  reset            in   1  synchronous, active-high
//  fix_coord_valid  in   1  1-cycle pulse; crosswalk coords ready; starts sequencing from IDLE
//  ped_req          in   1  pedestrian button, level or pulse; sampled every cycle
//  human_in_zone    in   1  pedestrian detected inside crosswalk window
//  tr_light         out  1  1 = car phase (GREEN, YELLOW), 0 = otherwise
//  tr_light_tick    out  1  1-cycle pulse on the first cycle of every tr_light change
//  car_lamp         out  3  {R,Y,G}
//  ped_lamp         out  2  {walk,stop}
//  sec_remain       out  7  seconds remaining in current state
//  phase            out  3  state encoding, for debug/overlay
// BEHAVIOUR
//  Reset: state=IDLE, tr_light=0, tr_light_tick=0, car_lamp=100, ped_lamp=01,
//   sec_remain=0, phase=0, prescaler=0, req latch=0, ext_cnt=0. Reset mid-state takes effect next edge.
//  States/phase codes: IDLE=0, GREEN=1, YELLOW=2, ALL_RED1=3, PED_WALK=4, PED_FLASH=5, ALL_RED2=6.
//  IDLE: wait for fix_coord_valid, then enter GREEN on the next edge. After leaving IDLE,
//   fix_coord_valid is ignored.
//  Prescaler counts 0..TICK_DIV-1. sec_tick is asserted when the count is TICK_DIV-1, then
//   the count wraps. Prescaler is cleared on every state entry.
//  On state entry, sec_remain is loaded with that state's *_S value. Each sec_tick decrements it.
//  A sec_tick with sec_remain==1 exits the state, so each state lasts exactly N*TICK_DIV cycles.
//  Transitions: GREEN->YELLOW->ALL_RED1->PED_WALK->PED_FLASH->ALL_RED2->GREEN.
//  Ped request: ped_req=1 sets the req latch in GREEN, YELLOW, ALL_RED1 and ALL_RED2.
//   It is ignored in PED_WALK and PED_FLASH. The latch is cleared on PED_WALK entry.
//  Green truncation: in GREEN, on a sec_tick with latch=1 and elapsed
//   (GREEN_S-sec_remain+1) >= MIN_GREEN_S, go to YELLOW.
//  Flash extension: in PED_FLASH, on a sec_tick with sec_remain==1, human_in_zone=1 and
//   ext_cnt<EXT_S: hold sec_remain=1 and increment ext_cnt; otherwise exit.
//   ext_cnt is cleared on PED_FLASH entry.
//  Outputs are registered and update in the same cycle as state.
//   tr_light=1 in GREEN and YELLOW only.
//   tr_light_tick=1 on the first cycle of GREEN (from IDLE or ALL_RED2) and of ALL_RED1.
//   car_lamp: GREEN=001, YELLOW=010, others=100.
//   ped_lamp: PED_WALK=10; PED_FLASH={blink,0}, where blink starts at 1 on entry and
//    toggles every sec_tick; others=01.
//   sec_remain=0 in IDLE.
//  Simultaneous events: reset beats everything. A sec_tick exit beats a ped_req latch
//   in the same cycle (the latch still sets if the state allows it).
// TESTING (TICK_DIV=4, GREEN_S=6, YELLOW_S=2, ALLRED_S=1, WALK_S=3, FLASH_S=2, MIN_GREEN_S=2, EXT_S=2)
//  Reset, fix_coord_valid at cycle 10 -> cycle 11: phase=1, tr_light=1, tick=1 for one cycle,
//   sec_remain=6; YELLOW at cycle 35; ALL_RED1 at 43 with tick=1, tr_light=0.
//  ped_req pulse at cycle 12 -> GREEN exits after 8 cycles (YELLOW at cycle 19).
//  human_in_zone=1 throughout PED_FLASH -> lasts (2+2)*4=16 cycles; ped_lamp walk toggles each tick.
//  ped_req during PED_WALK only -> next GREEN runs the full 24 cycles.
//  reset asserted mid-YELLOW -> next edge: phase=0, car_lamp=100, tr_light=0, sec_remain=0.
//  Second fix_coord_valid during GREEN -> no change to phase or sec_remain.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// Purpose : crosswalk signal sequencer (IDLE -> GREEN -> YELLOW -> ALL_RED1 -> PED_WALK -> PED_FLASH -> ALL_RED2 -> GREEN).
// Latency : all outputs are registered and change on the same edge as the state register.
// Backpr. : none; ped_req is latched and fix_coord_valid is only honoured while in IDLE.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   fix_coord_valid   1-cycle start pulse (used only in IDLE)
//   ped_req           pedestrian button, sampled every cycle
//   human_in_zone     pedestrian detected in the crosswalk (extends PED_FLASH)
//   tr_light          1 during the car phases (GREEN, YELLOW)
//   tr_light_tick     1-cycle pulse on entry to GREEN and to ALL_RED1
//   car_lamp          {R,Y,G}
//   ped_lamp          {walk,stop}
//   sec_remain        seconds left in the current state (0 in IDLE)
//   phase             state code for the overlay/debug
module traffic_light_ctrl #(
  parameter int TICK_DIV    = 100_000_000,
  parameter int GREEN_S     = 20,
  parameter int YELLOW_S    = 3,
  parameter int ALLRED_S    = 1,
  parameter int WALK_S      = 10,
  parameter int FLASH_S     = 5,
  parameter int MIN_GREEN_S = 5,
  parameter int EXT_S       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fix_coord_valid,
  input  logic       ped_req,
  input  logic       human_in_zone,
  output logic       tr_light,
  output logic       tr_light_tick,
  output logic [2:0] car_lamp,
  output logic [1:0] ped_lamp,
  output logic [6:0] sec_remain,
  output logic [2:0] phase
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  // Green may be cut once elapsed = GREEN_S - sec_remain + 1 reaches MIN_GREEN_S,
  // rewritten as sec_remain + MIN_GREEN_S <= GREEN_S + 1 to stay unsigned.
  localparam logic [7:0] MIN_GREEN_8 = 8'(MIN_GREEN_S);
  localparam logic [7:0] GREEN_P1_8  = 8'(GREEN_S + 1);
  localparam logic [6:0] EXT_MAX     = 7'(EXT_S);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GREEN     = 3'd1,
    S_YELLOW    = 3'd2,
    S_ALL_RED1  = 3'd3,
    S_PED_WALK  = 3'd4,
    S_PED_FLASH = 3'd5,
    S_ALL_RED2  = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [6:0]    sec_nxt;
  logic [6:0]    ext_cnt, ext_nxt;
  logic          req_latch, req_latch_nxt;
  logic          blink, blink_nxt;
  logic          entry;
  logic          sec_tick;
  logic          last_sec;
  logic          min_green_met;

  logic          tr_light_d;
  logic          tr_light_tick_d;
  logic [2:0]    car_lamp_d;
  logic [1:0]    ped_lamp_d;

  function automatic logic [6:0] load_secs(input state_t s);
    case (s)
      S_GREEN:     load_secs = 7'(GREEN_S);
      S_YELLOW:    load_secs = 7'(YELLOW_S);
      S_ALL_RED1:  load_secs = 7'(ALLRED_S);
      S_PED_WALK:  load_secs = 7'(WALK_S);
      S_PED_FLASH: load_secs = 7'(FLASH_S);
      S_ALL_RED2:  load_secs = 7'(ALLRED_S);
      default:     load_secs = 7'd0;
    endcase
  endfunction

  assign sec_tick      = (state != S_IDLE) && (presc == TICK_LAST);
  assign last_sec      = (sec_remain == 7'd1);
  assign min_green_met = ({1'b0, sec_remain} + MIN_GREEN_8) <= GREEN_P1_8;
  assign phase         = state;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      presc         <= '0;
      sec_remain    <= 7'd0;
      ext_cnt       <= 7'd0;
      req_latch     <= 1'b0;
      blink         <= 1'b0;
      tr_light      <= 1'b0;
      tr_light_tick <= 1'b0;
      car_lamp      <= 3'b100;
      ped_lamp      <= 2'b01;
    end else begin
      state         <= state_nxt;
      presc         <= presc_nxt;
      sec_remain    <= sec_nxt;
      ext_cnt       <= ext_nxt;
      req_latch     <= req_latch_nxt;
      blink         <= blink_nxt;
      tr_light      <= tr_light_d;
      tr_light_tick <= tr_light_tick_d;
      car_lamp      <= car_lamp_d;
      ped_lamp      <= ped_lamp_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_nxt = state;
    sec_nxt   = sec_remain;
    ext_nxt   = ext_cnt;
    blink_nxt = blink;

    case (state)
      S_IDLE: begin
        if (fix_coord_valid) state_nxt = S_GREEN;
      end
      S_GREEN: begin
        if (sec_tick) begin
          if (last_sec || (req_latch && min_green_met)) state_nxt = S_YELLOW;
          else                                          sec_nxt   = sec_remain - 7'd1;
        end
      end
      S_YELLOW: begin
        if (sec_tick) begin
          if (last_sec) state_nxt = S_ALL_RED1;
          else          sec_nxt   = sec_remain - 7'd1;
        end
      end
      S_ALL_RED1: begin
        if (sec_tick) begin
          if (last_sec) state_nxt = S_PED_WALK;
          else          sec_nxt   = sec_remain - 7'd1;
        end
      end
      S_PED_WALK: begin
        if (sec_tick) begin
          if (last_sec) state_nxt = S_PED_FLASH;
          else          sec_nxt   = sec_remain - 7'd1;
        end
      end
      S_PED_FLASH: begin
        if (sec_tick) begin
          blink_nxt = ~blink;
          if (last_sec) begin
            // Someone still crossing: hold at 1 s for another tick, bounded by EXT_S.
            if (human_in_zone && (ext_cnt < EXT_MAX)) ext_nxt   = ext_cnt + 7'd1;
            else                                      state_nxt = S_ALL_RED2;
          end else begin
            sec_nxt = sec_remain - 7'd1;
          end
        end
      end
      S_ALL_RED2: begin
        if (sec_tick) begin
          if (last_sec) state_nxt = S_GREEN;
          else          sec_nxt   = sec_remain - 7'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    entry = (state_nxt != state);
    if (entry) begin
      sec_nxt   = load_secs(state_nxt);
      ext_nxt   = 7'd0;
      blink_nxt = 1'b1;
    end

    if (entry || (state == S_IDLE) || sec_tick) presc_nxt = '0;
    else                                        presc_nxt = presc + PW'(1);

    // Entering the walk phase serves the request, so the clear wins over a same-cycle set.
    req_latch_nxt = req_latch;
    if (entry && (state_nxt == S_PED_WALK))
      req_latch_nxt = 1'b0;
    else if (ped_req && ((state == S_GREEN) || (state == S_YELLOW) ||
                         (state == S_ALL_RED1) || (state == S_ALL_RED2)))
      req_latch_nxt = 1'b1;
  end

  // Output decode from the upcoming state so lamps switch on the same edge as state.
  always_comb begin
    tr_light_d      = (state_nxt == S_GREEN) || (state_nxt == S_YELLOW);
    tr_light_tick_d = entry && ((state_nxt == S_GREEN) || (state_nxt == S_ALL_RED1));
    case (state_nxt)
      S_GREEN:  car_lamp_d = 3'b001;
      S_YELLOW: car_lamp_d = 3'b010;
      default:  car_lamp_d = 3'b100;
    endcase
    case (state_nxt)
      S_PED_WALK:  ped_lamp_d = 2'b10;
      S_PED_FLASH: ped_lamp_d = {blink_nxt, 1'b0};
      default:     ped_lamp_d = 2'b01;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Purpose : self-checking bench for traffic_light_ctrl against a seconds/cycles reference model.
// Latency : model advances on each rising edge; DUT outputs are compared on the falling edge.
// Backpr. : none; every phase wait is bounded by a cycle budget.
module tb_traffic_light_ctrl;

  localparam int TD    = 4;
  localparam int G_S   = 6;
  localparam int Y_S   = 2;
  localparam int AR_S  = 1;
  localparam int W_S   = 3;
  localparam int F_S   = 2;
  localparam int MIN_G = 2;
  localparam int EXT   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fix_coord_valid = 1'b0;
  logic       ped_req = 1'b0;
  logic       human_in_zone = 1'b0;
  logic       tr_light;
  logic       tr_light_tick;
  logic [2:0] car_lamp;
  logic [1:0] ped_lamp;
  logic [6:0] sec_remain;
  logic [2:0] phase;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase code, cycles spent in phase, current phase length in seconds.
  int m_ph    = 0;
  int m_cyc   = 0;
  int m_dur   = 0;
  int m_latch = 0;
  int m_ext   = 0;

  traffic_light_ctrl #(
    .TICK_DIV(TD), .GREEN_S(G_S), .YELLOW_S(Y_S), .ALLRED_S(AR_S),
    .WALK_S(W_S), .FLASH_S(F_S), .MIN_GREEN_S(MIN_G), .EXT_S(EXT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fix_coord_valid(fix_coord_valid),
    .ped_req(ped_req),
    .human_in_zone(human_in_zone),
    .tr_light(tr_light),
    .tr_light_tick(tr_light_tick),
    .car_lamp(car_lamp),
    .ped_lamp(ped_lamp),
    .sec_remain(sec_remain),
    .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int dur_of(input int p);
    case (p)
      1:       return G_S;
      2:       return Y_S;
      3:       return AR_S;
      4:       return W_S;
      5:       return F_S;
      6:       return AR_S;
      default: return 0;
    endcase
  endfunction

  task automatic m_enter(input int p);
    m_ph  = p;
    m_cyc = 0;
    m_dur = dur_of(p);
    if (p == 4) m_latch = 0;
    if (p == 5) m_ext = 0;
  endtask

  task automatic model_step();
    int nxt;
    int done;
    if (reset) begin
      m_ph = 0; m_cyc = 0; m_dur = 0; m_latch = 0; m_ext = 0;
    end else if (m_ph == 0) begin
      if (fix_coord_valid) m_enter(1);
    end else begin
      nxt = m_ph;
      if ((m_cyc + 1) % TD == 0) begin
        done = (m_cyc + 1) / TD;  // whole seconds completed in this phase
        if (m_ph == 1) begin
          if (done == m_dur || (m_latch != 0 && done >= MIN_G)) nxt = 2;
        end else if (m_ph == 5) begin
          if (done == m_dur) begin
            if (human_in_zone && m_ext < EXT) begin
              m_dur++;
              m_ext++;
            end else begin
              nxt = 6;
            end
          end
        end else if (done == m_dur) begin
          nxt = (m_ph == 6) ? 1 : m_ph + 1;
        end
      end
      if (ped_req && (m_ph == 1 || m_ph == 2 || m_ph == 3 || m_ph == 6)) m_latch = 1;
      if (nxt != m_ph) m_enter(nxt);
      else             m_cyc++;
    end
  endtask

  task automatic compare_all();
    int e_car;
    int e_ped;
    e_car = (m_ph == 1) ? 1 : (m_ph == 2) ? 2 : 4;
    if (m_ph == 4)      e_ped = 2;
    else if (m_ph == 5) e_ped = (((m_cyc / TD) % 2) == 0) ? 2 : 0;
    else                e_ped = 1;
    chk("phase", int'(phase), m_ph);
    chk("tr_light", int'(tr_light), (m_ph == 1 || m_ph == 2) ? 1 : 0);
    chk("tr_light_tick", int'(tr_light_tick), (m_cyc == 0 && (m_ph == 1 || m_ph == 3)) ? 1 : 0);
    chk("car_lamp", int'(car_lamp), e_car);
    chk("ped_lamp", int'(ped_lamp), e_ped);
    chk("sec_remain", int'(sec_remain), (m_ph == 0) ? 0 : m_dur - m_cyc / TD);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Steps until the DUT reaches phase p; n is the number of cycles taken.
  task automatic run_until(input int p, input int budget, output int n);
    n = 0;
    while (int'(phase) != p && n < budget) begin
      step();
      n++;
    end
    chk("reach_phase", int'(phase), p);
  endtask

  initial begin
    int n;

    // Reset and idle
    repeat (3) step();
    chk("rst_phase", int'(phase), 0);
    chk("rst_car", int'(car_lamp), 3'b100);
    chk("rst_ped", int'(ped_lamp), 2'b01);
    chk("rst_sec", int'(sec_remain), 0);
    reset = 1'b0;
    repeat (5) step();
    chk("idle_phase", int'(phase), 0);

    // Start and one full undisturbed cycle
    fix_coord_valid = 1'b1;
    step();
    fix_coord_valid = 1'b0;
    chk("start_phase", int'(phase), 1);
    chk("start_tick", int'(tr_light_tick), 1);
    chk("start_sec", int'(sec_remain), G_S);
    run_until(2, 200, n); chk("green_len", n, G_S * TD);
    run_until(3, 200, n); chk("yellow_len", n, Y_S * TD);
    chk("allred1_tick", int'(tr_light_tick), 1);
    chk("allred1_tr", int'(tr_light), 0);
    run_until(4, 200, n); chk("allred1_len", n, AR_S * TD);
    run_until(5, 200, n); chk("walk_len", n, W_S * TD);
    run_until(6, 200, n); chk("flash_len", n, F_S * TD);
    run_until(1, 200, n); chk("allred2_len", n, AR_S * TD);

    // Ped request on the second green cycle plus a stray start pulse
    step();
    ped_req = 1'b1;
    fix_coord_valid = 1'b1;
    step();
    ped_req = 1'b0;
    fix_coord_valid = 1'b0;
    chk("fcv_ignored_ph", int'(phase), 1);
    chk("fcv_ignored_sec", int'(sec_remain), G_S);
    run_until(2, 200, n); chk("trunc_green_len", n + 2, 8);
    run_until(4, 200, n);

    // Request only during walk; pedestrian lingers through flash
    ped_req = 1'b1;
    human_in_zone = 1'b1;
    run_until(5, 200, n);
    ped_req = 1'b0;
    run_until(6, 200, n); chk("ext_flash_len", n, (F_S + EXT) * TD);
    human_in_zone = 1'b0;
    run_until(1, 200, n);
    run_until(2, 200, n); chk("green_after_walk_req", n, G_S * TD);

    // Reset in the middle of yellow
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("midrst_phase", int'(phase), 0);
    chk("midrst_car", int'(car_lamp), 3'b100);
    chk("midrst_tr", int'(tr_light), 0);
    chk("midrst_sec", int'(sec_remain), 0);
    reset = 1'b0;

    // Randomized traffic checked against the model every cycle
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 499) == 0);
      fix_coord_valid = ($urandom_range(0, 19) == 0);
      ped_req         = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) human_in_zone = ~human_in_zone;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
